// File: rtl/softstart_seq.sv
// Soft-start sequencer: holds the 5V reference discharged, precharges it, then
// ramps the reference code at a fixed rate and flags power-good on completion.
module softstart_seq #(
  parameter int CODE_W   = 8,
  parameter int STEP_DIV = 16,
  parameter int PRE_CYC  = 32,
  parameter int FLT_CYC  = 64
) (
  input  logic              CELCLK,
  input  logic              CELRST,
  input  logic              CELV,
  input  logic              CELG,
  input  logic              SUB,
  input  logic              en,
  input  logic              uvlo_ok,
  input  logic              ocp,
  output logic [CODE_W-1:0] ss_code,
  output logic              ss_hold,
  output logic              pgood,
  output logic              fault,
  output logic [2:0]        state
);

  localparam int CNT_MAX = (PRE_CYC > FLT_CYC) ? PRE_CYC : FLT_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DIV_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0]  FLT_LAST  = CNT_W'(FLT_CYC - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [CODE_W-1:0] LAST_STEP = {{(CODE_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_RAMP  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t             cur, nxt;
  logic [CODE_W-1:0]  code_n;
  logic               hold_n, pgood_n, fault_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [DIV_W-1:0]   div, div_n;
  logic               go;

  // Supply/substrate pins are connectivity only.
  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  assign go    = en & uvlo_ok;
  assign state = cur;

  always_ff @(posedge CELCLK or posedge CELRST) begin
    if (CELRST) begin
      cur     <= S_IDLE;
      ss_code <= '0;
      ss_hold <= 1'b1;
      pgood   <= 1'b0;
      fault   <= 1'b0;
      cnt     <= '0;
      div     <= '0;
    end else begin
      cur     <= nxt;
      ss_code <= code_n;
      ss_hold <= hold_n;
      pgood   <= pgood_n;
      fault   <= fault_n;
      cnt     <= cnt_n;
      div     <= div_n;
    end
  end

  always_comb begin
    nxt     = cur;
    code_n  = ss_code;
    hold_n  = ss_hold;
    pgood_n = pgood;
    fault_n = fault;
    cnt_n   = cnt;
    div_n   = div;

    unique case (cur)
      S_IDLE: begin
        if (go) begin
          nxt   = S_PRE;
          cnt_n = '0;
        end
      end

      S_PRE: begin
        if (!go) begin
          nxt    = S_IDLE;
          code_n = '0;
          hold_n = 1'b1;
          cnt_n  = '0;
          div_n  = '0;
        end else if (cnt == PRE_LAST) begin
          nxt    = S_RAMP;
          hold_n = 1'b0;
          cnt_n  = '0;
          div_n  = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_RAMP, S_DONE: begin
        if (ocp) begin
          nxt     = S_FAULT;
          code_n  = '0;
          hold_n  = 1'b1;
          pgood_n = 1'b0;
          fault_n = 1'b1;
          cnt_n   = '0;
          div_n   = '0;
        end else if (!go) begin
          nxt     = S_IDLE;
          code_n  = '0;
          hold_n  = 1'b1;
          pgood_n = 1'b0;
          cnt_n   = '0;
          div_n   = '0;
        end else if (cur == S_RAMP) begin
          // Reaching full scale leaves RAMP, so the code cannot wrap.
          if (div == DIV_LAST) begin
            div_n  = '0;
            code_n = ss_code + 1'b1;
            if (ss_code == LAST_STEP) begin
              nxt     = S_DONE;
              pgood_n = 1'b1;
            end
          end else begin
            div_n = div + 1'b1;
          end
        end
      end

      S_FAULT: begin
        if (cnt == FLT_LAST) begin
          nxt     = S_IDLE;
          fault_n = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        nxt     = S_IDLE;
        code_n  = '0;
        hold_n  = 1'b1;
        pgood_n = 1'b0;
        fault_n = 1'b0;
        cnt_n   = '0;
        div_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_softstart_seq.sv
// Bench for softstart_seq: default and reduced-size instances driven by shared
// stimulus, each checked every cycle against a phase/age reference model.
module tb_softstart_seq;

  localparam int A_W = 8, A_DIV = 16, A_PRE = 32, A_FLT = 64;
  localparam int B_W = 4, B_DIV = 1,  B_PRE = 1,  B_FLT = 64;
  localparam int A_FULL = (1 << A_W) - 1;
  localparam int B_FULL = (1 << B_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, uvlo_ok = 1'b0, ocp = 1'b0;

  logic [A_W-1:0] code_a;
  logic [B_W-1:0] code_b;
  logic hold_a, pgood_a, fault_a, hold_b, pgood_b, fault_b;
  logic [2:0] st_a, st_b;

  always #5 clk = ~clk;

  softstart_seq #(.CODE_W(A_W), .STEP_DIV(A_DIV), .PRE_CYC(A_PRE), .FLT_CYC(A_FLT)) dut_a (
    .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .en(en), .uvlo_ok(uvlo_ok), .ocp(ocp),
    .ss_code(code_a), .ss_hold(hold_a), .pgood(pgood_a), .fault(fault_a), .state(st_a)
  );

  softstart_seq #(.CODE_W(B_W), .STEP_DIV(B_DIV), .PRE_CYC(B_PRE), .FLT_CYC(B_FLT)) dut_b (
    .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .en(en), .uvlo_ok(uvlo_ok), .ocp(ocp),
    .ss_code(code_b), .ss_hold(hold_b), .pgood(pgood_b), .fault(fault_b), .state(st_b)
  );

  // Model: current phase (0..4) and number of edges spent in it.
  typedef struct {
    int st;
    int age;
  } mdl_t;

  mdl_t ma, mb;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mstep(input mdl_t m, input bit go, input bit oc,
                                 input int pre, input int dv, input int full, input int flt);
    mdl_t r;
    r = m;
    case (m.st)
      0: if (go) begin r.st = 1; r.age = 0; end
      1: begin
        if (!go) begin r.st = 0; r.age = 0; end
        else begin
          r.age++;
          if (r.age == pre) begin r.st = 2; r.age = 0; end
        end
      end
      2: begin
        if (oc) begin r.st = 4; r.age = 0; end
        else if (!go) begin r.st = 0; r.age = 0; end
        else begin
          r.age++;
          if (r.age == full * dv) begin r.st = 3; r.age = 0; end
        end
      end
      3: begin
        if (oc) begin r.st = 4; r.age = 0; end
        else if (!go) begin r.st = 0; r.age = 0; end
      end
      default: begin
        r.age++;
        if (r.age == flt) begin r.st = 0; r.age = 0; end
      end
    endcase
    return r;
  endfunction

  function automatic int mcode(input mdl_t m, input int dv, input int full);
    if (m.st == 2) return m.age / dv;
    if (m.st == 3) return full;
    return 0;
  endfunction

  function automatic int mhold(input mdl_t m);
    return (m.st == 0 || m.st == 1 || m.st == 4) ? 1 : 0;
  endfunction

  task automatic compare_all();
    chk("A.state", int'(st_a), ma.st);
    chk("A.code",  int'(code_a), mcode(ma, A_DIV, A_FULL));
    chk("A.hold",  int'(hold_a), mhold(ma));
    chk("A.pgood", int'(pgood_a), (ma.st == 3) ? 1 : 0);
    chk("A.fault", int'(fault_a), (ma.st == 4) ? 1 : 0);
    chk("B.state", int'(st_b), mb.st);
    chk("B.code",  int'(code_b), mcode(mb, B_DIV, B_FULL));
    chk("B.hold",  int'(hold_b), mhold(mb));
    chk("B.pgood", int'(pgood_b), (mb.st == 3) ? 1 : 0);
    chk("B.fault", int'(fault_b), (mb.st == 4) ? 1 : 0);
  endtask

  // One clock: model follows the edge, outputs checked 1ns later, returns at negedge.
  task automatic tick();
    bit go;
    @(posedge clk);
    go = en & uvlo_ok;
    if (rst) begin
      ma = '{0, 0};
      mb = '{0, 0};
    end else begin
      ma = mstep(ma, go, ocp, A_PRE, A_DIV, A_FULL, A_FLT);
      mb = mstep(mb, go, ocp, B_PRE, B_DIV, B_FULL, B_FLT);
    end
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic run_until_code(input int target, input int budget);
    int k;
    k = 0;
    while (!(ma.st == 2 && mcode(ma, A_DIV, A_FULL) == target) && k < budget) begin
      tick();
      k++;
    end
    chk("reach_code", int'(code_a), target);
  endtask

  initial begin
    int lat_a, lat_b;
    ma = '{0, 0};
    mb = '{0, 0};

    // Reset values
    #1 rst = 1'b1;
    #1 compare_all();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Full ramp with go held; go first sampled on the next edge (i = 1)
    en = 1'b1;
    uvlo_ok = 1'b1;
    lat_a = -1;
    lat_b = -1;
    for (int i = 1; i <= 4200; i++) begin
      tick();
      if (lat_b < 0 && pgood_b) lat_b = i - 1;
      if (lat_a < 0 && pgood_a) begin
        lat_a = i - 1;
        break;
      end
    end
    chk("pgood_lat_A", lat_a, A_PRE + A_FULL * A_DIV);
    chk("pgood_lat_B", lat_b, B_PRE + B_FULL * B_DIV);
    chk("done_code_A", int'(code_a), 255);

    // UVLO glitch in DONE: IDLE, then immediate restart into PRE
    uvlo_ok = 1'b0;
    tick();
    chk("uvlo_idle", int'(st_a), 0);
    uvlo_ok = 1'b1;
    tick();
    chk("restart_pre", int'(st_a), 1);

    // ocp pulse at code 100: FAULT for exactly 64 edges, then restart
    run_until_code(100, 3000);
    ocp = 1'b1;
    tick();
    ocp = 1'b0;
    chk("ocp_fault_state", int'(st_a), 4);
    chk("ocp_fault_code", int'(code_a), 0);
    for (int i = 0; i < A_FLT - 1; i++) tick();
    chk("fault_still", int'(fault_a), 1);
    tick();
    chk("fault_exit", int'(st_a), 0);
    tick();
    chk("fault_restart", int'(st_a), 1);

    // ocp together with en drop: FAULT wins; en toggling does not shorten it
    run_until_code(50, 3000);
    ocp = 1'b1;
    en = 1'b0;
    tick();
    ocp = 1'b0;
    chk("ocp_beats_en", int'(st_a), 4);
    for (int i = 0; i < A_FLT - 1; i++) begin
      en = 1'($urandom_range(0, 1));
      tick();
    end
    chk("fault_len_toggle", int'(st_a), 4);
    en = 1'b1;
    tick();
    chk("fault_len_exit", int'(st_a), 0);

    // Asynchronous reset mid-ramp at code 200
    run_until_code(200, 4000);
    #2 rst = 1'b1;
    #1;
    ma = '{0, 0};
    mb = '{0, 0};
    chk("arst_state", int'(st_a), 0);
    chk("arst_code", int'(code_a), 0);
    chk("arst_hold", int'(hold_a), 1);
    compare_all();
    @(negedge clk);
    tick();
    rst = 1'b0;

    // ocp during PRE is ignored
    tick();
    chk("pre_entry", int'(st_a), 1);
    ocp = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    ocp = 1'b0;
    for (int i = 0; i < A_PRE; i++) tick();
    chk("pre_ocp_ignored", int'(st_a), 2);

    // Randomized stimulus
    for (int i = 0; i < 20000; i++) begin
      en      = ($urandom_range(0, 999) < 997);
      uvlo_ok = ($urandom_range(0, 999) < 998);
      ocp     = ($urandom_range(0, 999) < 2);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
